// File: rtl/ps2_dir_if.sv
// Byte stream from the PS/2 receiver, the controller's commit strobe, and the
// committed headings and start pulse returned to the game datapath.
interface ps2_dir_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       update;
  logic [1:0] dir_p1;
  logic [1:0] dir_p2;
  logic       start_pulse;

  modport master (output byte_valid, byte_in, update,
                  input  dir_p1, dir_p2, start_pulse);
  modport slave  (input  byte_valid, byte_in, update,
                  output dir_p1, dir_p2, start_pulse);
endinterface

// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code parser: E0/F0 prefix handling, per-player direction requests
// held pending until the controller's update strobe, 180-degree reversal filter.
module ps2_dir_decoder #(
  parameter int         TIMEOUT       = 1000000,
  parameter int         TO_W          = 20,
  parameter logic [1:0] P1_RESET_DIR  = 2'b11,
  parameter logic [1:0] P2_RESET_DIR  = 2'b10,
  parameter bit         ACCEPT_KEYPAD = 1'b1
) (
  input  logic     CLOCK_50,
  input  logic     resetn,
  ps2_dir_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [1:0]      dir_p1, dir_p2, pend_p1, pend_p2;
  logic [1:0]      req_p1, req_p2, ref_p1, ref_p2;
  logic            req_p1_v, req_p2_v, acc_p1, acc_p2;
  logic            start_nxt, start_q, to_hit;

  // {hit, dir} for the arrow / keypad codes shared by E0 and plain decode
  function automatic logic [2:0] arrow_dec(input logic [7:0] b);
    case (b)
      8'h75:   arrow_dec = 3'b1_01;
      8'h72:   arrow_dec = 3'b1_00;
      8'h6B:   arrow_dec = 3'b1_10;
      8'h74:   arrow_dec = 3'b1_11;
      default: arrow_dec = 3'b0_00;
    endcase
  endfunction

  function automatic logic [2:0] wasd_dec(input logic [7:0] b);
    case (b)
      8'h1D:   wasd_dec = 3'b1_01;
      8'h1B:   wasd_dec = 3'b1_00;
      8'h1C:   wasd_dec = 3'b1_10;
      8'h23:   wasd_dec = 3'b1_11;
      default: wasd_dec = 3'b0_00;
    endcase
  endfunction

  function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
    opposite = (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  assign to_hit = (to_cnt == TO_LAST);

  always_comb begin
    state_nxt  = state;
    req_p1_v   = 1'b0;
    req_p1     = 2'b00;
    req_p2_v   = 1'b0;
    req_p2     = 2'b00;
    start_nxt  = 1'b0;
    if (bus.byte_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.byte_in == 8'hE0)      state_nxt = S_EXT;
          else if (bus.byte_in == 8'hF0) state_nxt = S_BRK;
          else begin
            {req_p2_v, req_p2} = wasd_dec(bus.byte_in);
            if (ACCEPT_KEYPAD) {req_p1_v, req_p1} = arrow_dec(bus.byte_in);
            start_nxt = (bus.byte_in == 8'h29);
          end
        end
        S_EXT: begin
          if (bus.byte_in == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (bus.byte_in != 8'hE0) begin
            {req_p1_v, req_p1} = arrow_dec(bus.byte_in);
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    to_cnt_nxt = to_cnt + 1'b1;
    if (bus.byte_valid || state == S_IDLE || to_hit) to_cnt_nxt = '0;
  end

  // Reversal check is against the heading dir will hold after this edge
  assign ref_p1 = bus.update ? pend_p1 : dir_p1;
  assign ref_p2 = bus.update ? pend_p2 : dir_p2;
  assign acc_p1 = req_p1_v && !opposite(req_p1, ref_p1);
  assign acc_p2 = req_p2_v && !opposite(req_p2, ref_p2);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state   <= S_IDLE;
      to_cnt  <= '0;
      dir_p1  <= P1_RESET_DIR;
      pend_p1 <= P1_RESET_DIR;
      dir_p2  <= P2_RESET_DIR;
      pend_p2 <= P2_RESET_DIR;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      start_q <= start_nxt;
      if (acc_p1) pend_p1 <= req_p1;
      if (acc_p2) pend_p2 <= req_p2;
      if (bus.update) begin
        dir_p1 <= pend_p1;
        dir_p2 <= pend_p2;
      end
    end
  end

  assign bus.dir_p1      = dir_p1;
  assign bus.dir_p2      = dir_p2;
  assign bus.start_pulse = start_q;
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed plan plus randomized byte/update traffic against a sequence-level
// reference model of the PS/2 direction decoder.
module tb_ps2_dir_decoder;
  localparam int TIMEOUT = 64;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  ps2_dir_if bus ();

  ps2_dir_decoder #(.TIMEOUT(TIMEOUT), .TO_W(20), .P1_RESET_DIR(2'b11),
                    .P2_RESET_DIR(2'b10), .ACCEPT_KEYPAD(1'b1))
    dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bytes of an unfinished prefix sequence and idle edges since
  byte unsigned seq[$];
  int          gap;
  int          m_dir1, m_pend1, m_dir2, m_pend2;
  bit          m_start;

  function automatic int arrow_of(input byte unsigned b);
    case (b)
      8'h75: return 1;  8'h72: return 0;  8'h6B: return 2;  8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_of(input byte unsigned b);
    case (b)
      8'h1D: return 1;  8'h1B: return 0;  8'h1C: return 2;  8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_opp(input int a, input int b);
    return (a / 2 == b / 2) && (a != b);
  endfunction

  task automatic model_reset();
    seq.delete();
    gap = 0;
    m_dir1 = 3; m_pend1 = 3; m_dir2 = 2; m_pend2 = 2; m_start = 0;
  endtask

  task automatic model_edge(input bit bv, input byte unsigned b, input bit upd);
    int r1, r2, ref1, ref2;
    r1 = -1; r2 = -1;
    ref1 = upd ? m_pend1 : m_dir1;
    ref2 = upd ? m_pend2 : m_dir2;
    m_start = 0;
    if (bv) begin
      gap = 0;
      if (seq.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) seq.push_back(b);
        else begin
          r1 = arrow_of(b);
          r2 = wasd_of(b);
          m_start = (b == 8'h29);
        end
      end else if (seq.size() == 1 && seq[0] == 8'hE0) begin
        if (b == 8'hF0) seq.push_back(b);
        else if (b != 8'hE0) begin
          r1 = arrow_of(b);
          seq.delete();
        end
      end else begin
        seq.delete();
      end
    end else if (seq.size() != 0) begin
      gap++;
      if (gap >= TIMEOUT) begin seq.delete(); gap = 0; end
    end
    if (upd) begin m_dir1 = m_pend1; m_dir2 = m_pend2; end
    if (r1 >= 0 && !is_opp(r1, ref1)) m_pend1 = r1;
    if (r2 >= 0 && !is_opp(r2, ref2)) m_pend2 = r2;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("dir_p1", bus.dir_p1, 2'(m_dir1));
    chk("dir_p2", bus.dir_p2, 2'(m_dir2));
    chk("start_pulse", {1'b0, bus.start_pulse}, {1'b0, m_start});
  endtask

  // One clock: drive, let the edge happen, advance the model, compare
  task automatic cyc(input bit bv, input byte unsigned b, input bit upd);
    bus.byte_valid = bv;
    bus.byte_in    = b;
    bus.update     = upd;
    @(posedge CLOCK_50);
    if (!resetn) model_reset();
    else model_edge(bv, b, upd);
    #1;
    chk_model();
    bus.byte_valid = 1'b0;
    bus.update     = 1'b0;
  endtask

  task automatic send(input byte unsigned b);
    cyc(1'b1, b, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic upd();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b1, 8'hE0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    resetn = 1'b1;
  endtask

  byte unsigned pool[12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                             8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h12};

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.update     = 1'b0;
    model_reset();

    do_reset();
    chk("reset_dir_p1", bus.dir_p1, 2'b11);
    chk("reset_dir_p2", bus.dir_p2, 2'b10);
    chk("reset_start", {1'b0, bus.start_pulse}, 2'b00);
    upd();
    chk("idle_upd_p1", bus.dir_p1, 2'b11);

    send(8'hE0); send(8'h75); upd();
    chk("arrow_up_p1", bus.dir_p1, 2'b01);
    chk("arrow_up_p2", bus.dir_p2, 2'b10);

    do_reset();
    send(8'hE0); send(8'h6B); upd();
    chk("reverse_p1", bus.dir_p1, 2'b11);
    send(8'h1B); upd();
    chk("s_key_p2", bus.dir_p2, 2'b00);

    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h1D); upd();
    chk("break_p1", bus.dir_p1, 2'b11);
    chk("break_p2", bus.dir_p2, 2'b10);
    send(8'hE0); send(8'h1D); upd();
    chk("ext_discard_p2", bus.dir_p2, 2'b10);
    send(8'h1D); upd();
    chk("w_key_p2", bus.dir_p2, 2'b01);

    do_reset();
    send(8'hE0); send(8'h75); upd();
    send(8'hE0); send(8'h74);
    chk("pre_sim_p1", bus.dir_p1, 2'b01);
    cyc(1'b1, 8'h6B, 1'b1);
    chk("sim_drop_p1", bus.dir_p1, 2'b11);
    cyc(1'b1, 8'h72, 1'b1);
    chk("sim_hold_p1", bus.dir_p1, 2'b11);
    upd();
    chk("sim_commit_p1", bus.dir_p1, 2'b00);

    do_reset();
    send(8'hE0);
    for (int i = 0; i < TIMEOUT + 2; i++) cyc(1'b0, 8'h00, 1'b0);
    send(8'h75); upd();
    chk("timeout_keypad_p1", bus.dir_p1, 2'b01);
    cyc(1'b1, 8'h29, 1'b0);
    chk("start_hi", {1'b0, bus.start_pulse}, 2'b01);
    cyc(1'b0, 8'h00, 1'b0);
    chk("start_lo", {1'b0, bus.start_pulse}, 2'b00);
    send(8'hF0); cyc(1'b1, 8'h29, 1'b0);
    chk("brk_start", {1'b0, bus.start_pulse}, 2'b00);

    // Prefix expiring exactly at the boundary: byte on the firing edge keeps E0
    send(8'hE0);
    for (int i = 0; i < TIMEOUT - 2; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h1C, 1'b0);
    upd();

    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else if (r < 8) begin
        int n;
        n = $urandom_range(TIMEOUT - 3, TIMEOUT + 1);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, ($urandom_range(0, 9) == 0));
      end else begin
        bit bv;
        byte unsigned b;
        bv = ($urandom_range(0, 2) == 0);
        b  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
        cyc(bv, b, ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
Upstream stage of the game datapath. It consumes the raw byte stream from the PS/2 receiver and parses the E0 (extended) and F0 (break) prefixes. It turns make codes into per-player direction requests and holds them as pending until the controller's update strobe commits them. Player 1 uses the arrow keys and player 2 uses WASD; 180° reversals are rejected and the space bar produces a start pulse.

Parameters:
TIMEOUT, 1000000, cycles of silence after a prefix byte before the parser abandons the sequence (20 ms at 50 MHz)
TO_W, 20, width of the timeout counter
P1_RESET_DIR, 2'b11, committed and pending P1 direction after reset (right)
P2_RESET_DIR, 2'b10, committed and pending P2 direction after reset (left)
ACCEPT_KEYPAD, 1, when 1, non-prefixed 0x75/0x74/0x72/0x6B are also accepted as P1 directions

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  reset, synchronous, active-low
byte_valid  in  1  one-cycle strobe per received byte; the producer pulses once per byte
byte_in  in  8  received scan-code byte, valid while byte_valid=1
update  in  1  commit strobe from the game controller (one cycle per game step)
dir_p1  out  2  committed P1 heading
dir_p2  out  2  committed P2 heading
start_pulse  out  1  one-cycle pulse on a space make code

Behaviour:
- Direction encoding: 01 up, 00 down, 10 left, 11 right. bit1=0 means vertical, bit1=1 means horizontal.
- Opposite(a,b) is true when a[1]==b[1] and a[0]!=b[0].
- Reset (resetn=0 at a clock edge):
  - dir_p1 = pend_p1 = P1_RESET_DIR; dir_p2 = pend_p2 = P2_RESET_DIR.
  - start_pulse = 0; FSM = S_IDLE; timeout counter = 0.
  - Reset overrides any byte_valid or update in the same cycle, including mid-sequence.
- Parser FSM, advancing only on cycles with byte_valid=1:
  - S_IDLE:
    - 0xE0 -> S_EXT; 0xF0 -> S_BRK.
    - Otherwise plain decode and stay in S_IDLE: 0x1D -> P2 01, 0x1B -> P2 00, 0x1C -> P2 10, 0x23 -> P2 11, 0x29 -> start.
    - If ACCEPT_KEYPAD: 0x75 -> P1 01, 0x72 -> P1 00, 0x6B -> P1 10, 0x74 -> P1 11.
    - All other bytes are ignored.
  - S_EXT:
    - 0xF0 -> S_EXT_BRK; 0xE0 -> stay in S_EXT.
    - 0x75/0x72/0x6B/0x74 -> P1 request (same mapping as above), then S_IDLE.
    - Any other byte is discarded, then S_IDLE.
  - S_BRK and S_EXT_BRK: any byte is discarded (break codes never generate requests), then S_IDLE.
- Timeout:
  - The counter clears on every byte_valid and whenever the FSM is in S_IDLE; otherwise it increments.
  - When the counter reaches TIMEOUT-1 the FSM goes to S_IDLE on the next edge and the counter clears.
  - If byte_valid arrives on that same edge, the byte is processed normally and the timeout does not fire.
- Request acceptance, for each player independently:
  - Reference heading ref = update ? pend : dir, i.e. the value dir will hold after this edge.
  - If Opposite(req, ref), the request is dropped. Otherwise pend <= req on the edge where the byte is sampled.
  - A request equal to ref is accepted (no-op).
- Commit: on an edge with update=1, dir_p1 <= pend_p1 and dir_p2 <= pend_p2. This uses the pend value from before the edge, so a byte accepted in the same cycle lands in pend for the next update.
- Latency:
  - byte -> pend: 1 edge.
  - pend -> dir: the next edge with update=1.
  - start_pulse: high for exactly the one cycle after the edge that sampled 0x29 in S_IDLE.
- A newer accepted request overwrites an older uncommitted one (last-wins).

Test Plan:
- Reset: release resetn -> dir_p1=11, dir_p2=10, start_pulse=0. Apply update with no bytes -> outputs unchanged.
- Arrow-up commit: bytes E0,75, then update -> dir_p1=01 on the update edge, dir_p2 still 10.
- Reversal reject: with dir_p1=11, bytes E0,6B then update -> dir_p1 stays 11. Then bytes 1B (S) with dir_p2=10, then update -> dir_p2=00.
- Break and prefix handling:
  - Bytes E0,F0,75 and F0,1D -> no change to either pend.
  - Bytes E0,1D -> discarded; a following 1D -> dir_p2=01 after update.
- Simultaneous byte and update: dir_p1=01, pend_p1=11.
  - Byte 6B (keypad) in the same cycle as update -> dropped (opposite of 11); dir_p1=11.
  - Then byte 72 with update -> dir_p1 stays 11 and pend_p1=00, committed to dir_p1=00 on the next update.
- Timeout and start: E0, then idle for TIMEOUT+2 cycles, then 75 -> P1 request accepted only if ACCEPT_KEYPAD=1. Byte 29 -> start_pulse high for exactly 1 cycle; F0,29 -> no pulse.
